// File: rtl/tpu_pkg.sv
// Shared definitions for the A-matrix load path feeding the systolic array.
package tpu_pkg;

    localparam int BITS_AB_DEF = 8;
    localparam int DIM_DEF     = 8;

    // Loader sequencing states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef logic signed [BITS_AB_DEF-1:0] a_elem_t;

endpackage

// File: rtl/mema_row_packer.sv
// Packs a row-major element stream into one DIM-wide row register.
// row_full flags the transfer that completes the row (combinational on load).
module mema_row_packer #(
    parameter int BITS_AB = tpu_pkg::BITS_AB_DEF,
    parameter int DIM     = tpu_pkg::DIM_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      load,
    input  logic signed [BITS_AB-1:0] data,
    output logic signed [BITS_AB-1:0] Ain [DIM],
    output logic                      row_full
);

    localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(DIM - 1);

    logic [CW-1:0] col;

    assign row_full = load && (col == COL_LAST);

    // Column pointer and row storage; contents persist between writes
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            for (int i = 0; i < DIM; i++) begin
                Ain[i] <= '0;
            end
        end else if (clr) begin
            col <= '0;
        end else if (load) begin
            Ain[col] <= data;
            col      <= row_full ? '0 : col + CW'(1);
        end
    end

endmodule

// File: rtl/mema_loader.sv
// A-matrix loader: packs DIM rows of DIM signed elements, writes each row into
// the skew buffer, then holds the shift enable for the drain window and pulses done.
// Optional build macro MEMA_LOADER_PERF_EN adds perf_cycles / stall_cycles counters.
//
// state | meaning
// IDLE  | waiting for start, no handshake
// LOAD  | accepting elements into the row packer
// WRITE | one-cycle row write strobe to the skew buffer
// DRAIN | en held high for DRAIN_CYCLES cycles
// DONE  | one-cycle completion pulse
module mema_loader
    import tpu_pkg::*;
#(
    parameter int BITS_AB      = BITS_AB_DEF,
    parameter int DIM          = DIM_DEF,
    parameter int DRAIN_CYCLES = 3*DIM - 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [BITS_AB-1:0] in_data,
    output logic signed [BITS_AB-1:0] Ain [DIM],
    output logic [$clog2(DIM)-1:0]    Arow,
    output logic                      WrEn,
    output logic                      en,
    output logic                      busy,
`ifdef MEMA_LOADER_PERF_EN
    output logic [31:0]               perf_cycles,
    output logic [31:0]               stall_cycles,
`endif
    output logic                      done
);

    localparam int RW = $clog2(DIM);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(DIM - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    state_t          state;
    logic [RW-1:0]   row;
    logic [DW-1:0]   dcnt;
    logic            row_full;
    logic            accept_start;
    logic            xfer;

    assign accept_start = (state == IDLE) && start;
    assign xfer         = in_valid && in_ready;

    assign in_ready = (state == LOAD);
    assign WrEn     = (state == WRITE);
    assign en       = (state == DRAIN);
    assign done     = (state == DONE);
    assign busy     = (state != IDLE);
    assign Arow     = row;

    mema_row_packer #(
        .BITS_AB (BITS_AB),
        .DIM     (DIM)
    ) u_packer (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept_start),
        .load     (xfer),
        .data     (in_data),
        .Ain      (Ain),
        .row_full (row_full)
    );

    // Sequencer: state, row index and drain counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            row   <= '0;
            dcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        row   <= '0;
                    end
                end
                LOAD: begin
                    if (row_full) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (row == ROW_LAST) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                    end else begin
                        row   <= row + RW'(1);
                        state <= LOAD;
                    end
                end
                DRAIN: begin
                    if (dcnt == DRAIN_LAST) begin
                        state <= DONE;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEMA_LOADER_PERF_EN
    // Busy and stall cycle counters; they stop once the sequence returns to IDLE
    always_ff @(posedge clk) begin
        if (rst || accept_start) begin
            perf_cycles  <= '0;
            stall_cycles <= '0;
        end else if (busy) begin
            perf_cycles <= perf_cycles + 32'd1;
            if ((state == LOAD) && !in_valid) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mema_loader.sv
// Scoreboard bench for mema_loader (DIM=8). The driver pushes expected row
// writes and done timing; a negedge monitor pops and compares on WrEn / done.
module tb_mema_loader;

    localparam int BITS_AB = 8;
    localparam int DIM     = 8;
    localparam int DRAIN   = 3*DIM - 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      start;
    logic                      in_valid;
    logic                      in_ready;
    logic signed [BITS_AB-1:0] in_data;
    logic signed [BITS_AB-1:0] Ain [DIM];
    logic [2:0]                Arow;
    logic                      WrEn;
    logic                      en;
    logic                      busy;
    logic                      done;
`ifdef MEMA_LOADER_PERF_EN
    logic [31:0]               perf_cycles;
    logic [31:0]               stall_cycles;
`endif

    always #5 clk = ~clk;

    mema_loader #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .Ain      (Ain),
        .Arow     (Arow),
        .WrEn     (WrEn),
        .en       (en),
        .busy     (busy),
`ifdef MEMA_LOADER_PERF_EN
        .perf_cycles  (perf_cycles),
        .stall_cycles (stall_cycles),
`endif
        .done     (done)
    );

    int nchk  = 0;
    int nfail = 0;

    int exp_row [$];
    int exp_cyc [$];
    int exp_val [$];
    int exp_done[$];

    int cyc      = 0;
    int en_cnt   = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: cycle numbering restarts at each accepted start (cycle 1 = first LOAD cycle)
    always @(negedge clk) begin
        int r, c, v;
        cyc++;
        chk("wren_en_exclusive", int'(WrEn && en), 0);
        if (en) en_cnt++;
        if (WrEn) begin
            chk("wren_expected", exp_row.size() > 0 ? 1 : 0, 1);
            if (exp_row.size() > 0) begin
                r = exp_row.pop_front();
                c = exp_cyc.pop_front();
                chk("arow", int'(Arow), r);
                chk($sformatf("wren_cycle_row%0d", r), cyc, c);
                for (int k = 0; k < DIM; k++) begin
                    v = exp_val.pop_front();
                    chk($sformatf("ain_row%0d_col%0d", r, k), int'(Ain[k]), v);
                end
            end
        end
        if (done) begin
            done_cnt++;
            chk("done_expected", exp_done.size() > 0 ? 1 : 0, 1);
            if (exp_done.size() > 0) begin
                c = exp_done.pop_front();
                chk("done_cycle", cyc, c);
                chk("en_high_cycles", en_cnt, DRAIN);
            end
        end
        if (start && !busy && !rst) begin
            cyc    = 0;
            en_cnt = 0;
        end
    end

    int elem [DIM*DIM];

    task automatic run_seq(input int pat, input int stall_len, input bit poke_start,
                           input bit expect_done);
        int i, sc, guard, d0, k;
        for (int n = 0; n < DIM*DIM; n++) begin
            case (pat)
                0:       elem[n] = n;
                1:       elem[n] = (n % 2 == 0) ? -128 : 127;
                default: elem[n] = ((n * 37) % 256) - 128;
            endcase
        end
        for (int r = 0; r < DIM; r++) begin
            exp_row.push_back(r);
            exp_cyc.push_back((DIM + 1) * (r + 1) + ((r >= 2) ? stall_len : 0));
            for (int c = 0; c < DIM; c++) exp_val.push_back(elem[r*DIM + c]);
        end
        if (expect_done) exp_done.push_back(DIM * (DIM + 1) + DRAIN + 1 + stall_len);
        d0 = done_cnt;

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        i = 0; sc = 0; guard = 0;
        while (i < DIM*DIM && guard < 500) begin
            if (i == 20 && sc < stall_len) begin
                in_valid = 1'b0;
                if (in_ready) sc++;
            end else begin
                in_valid = 1'b1;
                in_data  = elem[i][BITS_AB-1:0];
                if (in_ready) i++;
            end
            start = (poke_start && i == 30);
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("feed_complete", i, DIM*DIM);

        if (poke_start) begin
            k = 0;
            while (!en && k < 50) begin @(negedge clk); k++; end
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (expect_done) begin
            k = 0;
            while (done_cnt == d0 && k < 300) begin @(negedge clk); k++; end
            @(negedge clk);
            chk("done_arrived", done_cnt, d0 + 1);
            chk("wr_queue_empty", exp_row.size(), 0);
        end
    endtask

    initial begin
        int k, d0, anyz;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_en", int'(en), 0);
        chk("rst_wren", int'(WrEn), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_arow", int'(Arow), 0);
        anyz = 0;
        for (int j = 0; j < DIM; j++) if (Ain[j] !== '0) anyz++;
        chk("rst_ain_nonzero_count", anyz, 0);
        rst = 1'b0;
        in_valid = 1'b1; in_data = 8'sd5;
        repeat (3) begin
            @(negedge clk);
            chk("idle_in_ready", int'(in_ready), 0);
        end
        chk("idle_ain0_unchanged", int'(Ain[0]), 0);
        in_valid = 1'b0;

        run_seq(0, 0, 1'b0, 1'b1);
        run_seq(2, 5, 1'b0, 1'b1);
`ifdef MEMA_LOADER_PERF_EN
        chk("perf_cycles", int'(perf_cycles), 100);
        chk("stall_cycles", int'(stall_cycles), 5);
`endif
        run_seq(1, 0, 1'b1, 1'b1);

        // Reset during drain after 10 en cycles
        run_seq(0, 0, 1'b0, 1'b0);
        d0 = done_cnt;
        k = 0;
        while (k < 10) begin
            @(negedge clk);
            if (en) k++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_en", int'(en), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_arow", int'(Arow), 0);
        repeat (30) @(negedge clk);
        chk("midrst_no_done", done_cnt, d0);

        run_seq(2, 0, 1'b0, 1'b1);
        chk("done_total", done_cnt, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
